// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation codes, FSM state encoding, the latched-operation record
// and small decode helpers.
package muldiv_ctrl_pkg;

  localparam int MD_OPT_WIDTH = 3;
  localparam int MD_DATA_W    = 32;

  typedef logic [MD_OPT_WIDTH-1:0] md_opt_t;

  // Operation codes; 3'd6 and 3'd7 are undefined and raise illegal_opt.
  localparam md_opt_t MD_OPT_MULT  = 3'd0;
  localparam md_opt_t MD_OPT_MULTU = 3'd1;
  localparam md_opt_t MD_OPT_DIV   = 3'd2;
  localparam md_opt_t MD_OPT_DIVU  = 3'd3;
  localparam md_opt_t MD_OPT_MTHI  = 3'd4;
  localparam md_opt_t MD_OPT_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } md_state_e;

  // Everything about the running operation that FIXUP needs besides
  // the accumulator itself.
  typedef struct packed {
    logic is_div;     // divide (else multiply)
    logic is_signed;  // MULT / DIV
    logic neg_res;    // negate product / quotient
    logic neg_rem;    // negate remainder (dividend was negative)
    logic div_zero;   // divisor was zero
  } md_op_t;

  // True for the four opts that run the 32-step loop.
  function automatic logic is_arith_opt(input md_opt_t opt);
    return (opt == MD_OPT_MULT) || (opt == MD_OPT_MULTU) ||
           (opt == MD_OPT_DIV)  || (opt == MD_OPT_DIVU);
  endfunction

  // Magnitude of a 32-bit operand when treated as signed; 0x80000000
  // maps to itself, which is the correct unsigned magnitude.
  function automatic logic [MD_DATA_W-1:0] abs_if(input logic [MD_DATA_W-1:0] v,
                                                  input logic is_signed);
    return (is_signed && v[MD_DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between the execute stage (master) and the
// multiply/divide sequencer (slave).
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic                 start;
  md_opt_t              opt;
  logic [MD_DATA_W-1:0] opr1;
  logic [MD_DATA_W-1:0] opr2;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic [MD_DATA_W-1:0] hi;
  logic [MD_DATA_W-1:0] lo;
  logic                 illegal_opt;

  modport master (
    output start, opt, opr1, opr2, flush,
    input  busy, done, hi, lo, illegal_opt
  );

  modport slave (
    input  start, opt, opr1, opr2, flush,
    output busy, done, hi, lo, illegal_opt
  );
endinterface

// File: rtl/muldiv_ctrl_step.sv
// One iteration of the unsigned shift-add multiplier or restoring
// divider, operating on a 64-bit accumulator.
//   multiply: acc = {partial_product_hi, remaining_multiplier}
//   divide:   acc = {partial_remainder, remaining_dividend/quotient}
module muldiv_ctrl_step
  import muldiv_ctrl_pkg::*;
(
  input  logic                   is_div,
  input  logic [2*MD_DATA_W-1:0] acc_in,
  input  logic [MD_DATA_W-1:0]   operand,   // multiplicand or divisor
  output logic [2*MD_DATA_W-1:0] acc_out
);

  logic [MD_DATA_W:0]   sum;
  logic [MD_DATA_W:0]   trial;
  logic [MD_DATA_W-1:0] diff;
  logic                 q_bit;

  // Single combinational step, selected by is_div.
  // NOTE: every output of an always_comb gets a default before any
  // branch so no path leaves it unassigned (that would infer a latch).
  always_comb begin
    acc_out = '0;
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift right keeping the carry.
    sum   = {1'b0, acc_in[2*MD_DATA_W-1:MD_DATA_W]} + {1'b0, operand};
    // Divide: partial remainder shifted left with the next dividend bit.
    trial = acc_in[2*MD_DATA_W-1:MD_DATA_W-1];
    q_bit = (trial >= {1'b0, operand});
    // Only used when trial >= operand, so the result fits in 32 bits.
    diff  = trial[MD_DATA_W-1:0] - operand;
    if (is_div) begin
      if (q_bit) acc_out = {diff, acc_in[MD_DATA_W-2:0], 1'b1};
      else       acc_out = {trial[MD_DATA_W-1:0], acc_in[MD_DATA_W-2:0], 1'b0};
    end else begin
      if (acc_in[0]) acc_out = {sum, acc_in[MD_DATA_W-1:1]};
      else           acc_out = {1'b0, acc_in[2*MD_DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// IDLE accepts one op per start pulse; MULT*/DIV* run ITER iterations
// in CALC, then FIXUP applies signs and writes HI/LO. MTHI/MTLO write
// directly from IDLE in one cycle.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int ITER = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(ITER);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(ITER - 1);

  md_state_e state_q, state_d;
  cnt_t      cnt_q;

  logic [2*MD_DATA_W-1:0] acc_q, acc_step, prod;
  logic [MD_DATA_W-1:0]   opnd_q;   // multiplicand or divisor magnitude
  logic [MD_DATA_W-1:0]   raw1_q;   // opr1 as given, for divide-by-zero HI
  logic [MD_DATA_W-1:0]   hi_q, lo_q, res_hi, res_lo, mag1, mag2;
  logic [MD_DATA_W-1:0]   quo, rem;
  md_op_t                 op_q, op_in;
  logic                   done_q, illegal_q;

  logic accept, load_op, wr_hi, wr_lo, bad_opt, step_en, commit, last_iter;
  logic busy_c;

  // Decode the requested opt into the latched-operation record.
  always_comb begin
    op_in           = '0;
    op_in.is_div    = (bus.opt == MD_OPT_DIV)  || (bus.opt == MD_OPT_DIVU);
    op_in.is_signed = (bus.opt == MD_OPT_MULT) || (bus.opt == MD_OPT_DIV);
    op_in.neg_res   = op_in.is_signed && (bus.opr1[MD_DATA_W-1] ^ bus.opr2[MD_DATA_W-1]);
    op_in.neg_rem   = op_in.is_signed && bus.opr1[MD_DATA_W-1];
    op_in.div_zero  = op_in.is_div && (bus.opr2 == '0);
    mag1            = abs_if(bus.opr1, op_in.is_signed);
    mag2            = abs_if(bus.opr2, op_in.is_signed);
  end

  // State register.
  // NOTE: sequential state is assigned with <= so every flop samples
  // the pre-edge values of its sources, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush aborts CALC/FIXUP without a result.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (load_op) state_d = ST_CALC;
      ST_CALC: begin
        if (bus.flush)      state_d = ST_IDLE;
        else if (last_iter) state_d = ST_FIXUP;
      end
      ST_FIXUP: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output/strobe decode from state and the sampled request.
  always_comb begin
    busy_c    = (state_q != ST_IDLE);
    // A start is honoured only in IDLE and only when not flushed.
    accept    = (state_q == ST_IDLE) && bus.start && !bus.flush;
    load_op   = accept && is_arith_opt(bus.opt);
    wr_hi     = accept && (bus.opt == MD_OPT_MTHI);
    wr_lo     = accept && (bus.opt == MD_OPT_MTLO);
    bad_opt   = accept && !is_arith_opt(bus.opt) && !wr_hi && !wr_lo;
    step_en   = (state_q == ST_CALC) && !bus.flush;
    commit    = (state_q == ST_FIXUP) && !bus.flush;
    last_iter = (cnt_q == CNT_LAST);
  end

  muldiv_ctrl_step u_step (
    .is_div  (op_q.is_div),
    .acc_in  (acc_q),
    .operand (opnd_q),
    .acc_out (acc_step)
  );

  // Operand latch, iteration counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      raw1_q <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else if (load_op) begin
      op_q   <= op_in;
      raw1_q <= bus.opr1;
      cnt_q  <= '0;
      if (op_in.is_div) begin
        acc_q  <= {{MD_DATA_W{1'b0}}, mag1};
        opnd_q <= mag2;
      end else begin
        acc_q  <= {{MD_DATA_W{1'b0}}, mag2};
        opnd_q <= mag1;
      end
    end else if (step_en) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Sign fix-up of the unsigned loop result.
  always_comb begin
    prod   = op_q.neg_res ? (~acc_q + 1'b1) : acc_q;
    quo    = acc_q[MD_DATA_W-1:0];
    rem    = acc_q[2*MD_DATA_W-1:MD_DATA_W];
    res_hi = prod[2*MD_DATA_W-1:MD_DATA_W];
    res_lo = prod[MD_DATA_W-1:0];
    if (op_q.is_div) begin
      if (op_q.div_zero) begin
        res_lo = '1;
        res_hi = raw1_q;
      end else begin
        res_lo = op_q.neg_res ? (~quo + 1'b1) : quo;
        res_hi = op_q.neg_rem ? (~rem + 1'b1) : rem;
      end
    end
  end

  // Architectural HI/LO: loop result at FIXUP, else MTHI/MTLO from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else begin
      if (wr_hi) hi_q <= bus.opr1;
      if (wr_lo) lo_q <= bus.opr1;
    end
  end

  // Registered single-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= commit;
      illegal_q <= bad_opt;
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.illegal_opt = illegal_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table of MULT*/DIV*
// results scored through a queue on each done pulse, plus hand-written
// sequences for MTHI/MTLO, illegal opts, start-while-busy, back-to-back
// issue, flush and asynchronous reset mid-operation.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  muldiv_ctrl_if bus ();

  muldiv_ctrl #(.ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    md_opt_t     opt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          e0;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input md_opt_t opt, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] hi, input logic [31:0] lo, input string name);
    vec_t v;
    v.opt = opt; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo, input string name);
    exp_t e;
    e.hi = hi; e.lo = lo; e.e0 = cyc; e.name = name;
    sb.push_back(e);
  endtask

  // Scoreboard: every done pulse must match the oldest expected result
  // and arrive 33 edges after the accepting edge.
  task automatic score();
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_done", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({e.name, "_hi"}, bus.hi, e.hi);
      check({e.name, "_lo"}, bus.lo, e.lo);
      check({e.name, "_latency"}, cyc - e.e0, 33);
    end
  endtask

  always @(negedge clk) if (rst_n && bus.done) score();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request now; it is sampled on the next edge (E0).
  task automatic send(input md_opt_t opt, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.opt   = opt;
    bus.opr1  = a;
    bus.opr2  = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Bounded wait for done; returns at the negedge where done is high.
  task automatic wait_done(input string name);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.done) found = 1;
    end
    check({name, "_done_seen"}, 64'(found), 64'd1);
    if (found) check({name, "_busy_low_at_done"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;

    add(MD_OPT_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, "multu_max_x2");
    add(MD_OPT_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, "mult_m1_x2");
    add(MD_OPT_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2");
    add(MD_OPT_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu_100_7");
    add(MD_OPT_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, "divu_by_zero");
    add(MD_OPT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, "div_min_m1");
    add(MD_OPT_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, "mult_m3_5");
    add(MD_OPT_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_7_m2");
    add(MD_OPT_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        "div_m7_m2");
    add(MD_OPT_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, "multu_shift4");
    add(MD_OPT_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div_signed_by_zero");
    add(MD_OPT_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        "mult_min_min");
    add(MD_OPT_DIVU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        "divu_max_max");

    bus.start = 1'b0;
    bus.opt   = '0;
    bus.opr1  = '0;
    bus.opr2  = '0;
    bus.flush = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_hi",      bus.hi,          64'd0);
    check("reset_lo",      bus.lo,          64'd0);
    check("reset_busy",    bus.busy,        64'd0);
    check("reset_done",    bus.done,        64'd0);
    check("reset_illegal", bus.illegal_opt, 64'd0);

    // Vector table.
    foreach (vecs[i]) begin
      tick();
      send(vecs[i].opt, vecs[i].a, vecs[i].b);
      push_exp(vecs[i].hi, vecs[i].lo, vecs[i].name);
      check({vecs[i].name, "_busy"}, bus.busy, 64'd1);
      wait_done(vecs[i].name);
    end

    // MTHI then MTLO on consecutive cycles.
    tick();
    bus.start = 1'b1; bus.opt = MD_OPT_MTHI; bus.opr1 = 32'h12345678;
    tick();
    bus.opt = MD_OPT_MTLO; bus.opr1 = 32'hCAFEBABE;
    check("mthi_hi",   bus.hi,   64'h12345678);
    check("mthi_busy", bus.busy, 64'd0);
    tick();
    bus.start = 1'b0;
    check("mtlo_lo",   bus.lo,   64'hCAFEBABE);
    check("mtlo_hi",   bus.hi,   64'h12345678);
    check("mtlo_busy", bus.busy, 64'd0);

    // Undefined opt.
    tick();
    send(3'd6, 32'hDEADBEEF, 32'd1);
    check("illegal_pulse", bus.illegal_opt, 64'd1);
    check("illegal_busy",  bus.busy,        64'd0);
    check("illegal_hi",    bus.hi,          64'h12345678);
    tick();
    check("illegal_one_cycle", bus.illegal_opt, 64'd0);

    // Start while busy is ignored.
    tick();
    send(MD_OPT_MULTU, 32'h00010000, 32'h00010000);
    push_exp(32'd1, 32'd0, "busy_first");
    repeat (5) tick();
    send(MD_OPT_DIVU, 32'd9, 32'd3);
    check("busy_start_busy",    bus.busy,        64'd1);
    check("busy_start_illegal", bus.illegal_opt, 64'd0);
    wait_done("busy_first");

    // Back-to-back: next start issued in the done cycle.
    tick();
    send(MD_OPT_MULTU, 32'd3, 32'd4);
    push_exp(32'd0, 32'd12, "b2b_first");
    wait_done("b2b_first");
    send(MD_OPT_MULT, 32'd7, 32'hFFFFFFFF);
    push_exp(32'hFFFFFFFF, 32'hFFFFFFF9, "b2b_second");
    check("b2b_busy", bus.busy, 64'd1);
    wait_done("b2b_second");

    // Flush at CALC iteration 10 with HI/LO preloaded.
    tick();
    bus.start = 1'b1; bus.opt = MD_OPT_MTHI; bus.opr1 = 32'hAAAAAAAA;
    tick();
    bus.opt = MD_OPT_MTLO; bus.opr1 = 32'h55555555;
    tick();
    bus.start = 1'b0;
    send(MD_OPT_MULTU, 32'hFFFFFFFF, 32'd2);
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 64'd0);
    check("flush_hi",   bus.hi,   64'hAAAAAAAA);
    check("flush_lo",   bus.lo,   64'h55555555);
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) saw = 1;
    end
    check("flush_no_done",  64'(saw), 64'd0);
    check("flush_hi_later", bus.hi,   64'hAAAAAAAA);

    // Flush together with start in IDLE: start dropped.
    tick();
    bus.flush = 1'b1;
    send(MD_OPT_MTHI, 32'h0BADF00D, 32'd0);
    bus.flush = 1'b0;
    check("flush_start_hi",   bus.hi,   64'hAAAAAAAA);
    check("flush_start_busy", bus.busy, 64'd0);

    // Asynchronous reset mid-CALC.
    tick();
    send(MD_OPT_DIVU, 32'd100, 32'd7);
    repeat (9) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_hi",   bus.hi,   64'd0);
    check("rst_mid_lo",   bus.lo,   64'd0);
    check("rst_mid_busy", bus.busy, 64'd0);
    check("rst_mid_done", bus.done, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery after reset.
    tick();
    send(MD_OPT_DIVU, 32'd100, 32'd7);
    push_exp(32'd2, 32'd14, "after_reset");
    wait_done("after_reset");

    repeat (5) tick();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer that owns the architectural HI/LO registers and executes MULT, MULTU, DIV and DIVU beside the single-cycle ALU. It sits in the execute stage and accepts one operation at a time via a start pulse. It holds `busy` while a 32-step shift-add or restoring-divide loop runs. The pipeline stalls on `busy` before any HI/LO access, and moves to/from HI/LO complete in one cycle when idle.

## Interface
- `ITER`, 32: iteration count; equals operand width; not meant to be overridden.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `opt`  in  `MD_OPT_WIDTH`  operation, sampled with `start`.
- `opr1`  in  32  multiplicand, dividend, or MTHI/MTLO source.
- `opr2`  in  32  multiplier or divisor.
- `flush`  in  1  exception flush; aborts the running operation.
- `busy`  out  1  high while state is not IDLE.
- `done`  out  1  one-cycle pulse after HI/LO are written by MULT*/DIV*.
- `hi`, `lo`  out  32 each  current HI/LO register values, driven directly by the registers.
- `illegal_opt`  out  1  one-cycle pulse: `start` with an undefined opt.

## Operation
- Opts: `MD_OPT_MULT`, `MD_OPT_MULTU`, `MD_OPT_DIV`, `MD_OPT_DIVU`, `MD_OPT_MTHI`, `MD_OPT_MTLO`.
- Reset values: hi=0, lo=0, busy=0, done=0, illegal_opt=0, state IDLE, counter 0.
- States:
  - IDLE: `start` with MULT*/DIV* goes to CALC. It latches operand magnitudes (abs value for signed opts), the result sign bits and the opt, and clears the counter and partial accumulator.
  - IDLE: MTHI/MTLO write `opr1` into hi/lo at that edge and stay in IDLE.
  - IDLE: an undefined opt pulses `illegal_opt` and changes nothing.
  - CALC: one iteration per cycle.
    - Multiply: 64-bit accumulator shift-add on the multiplier LSB.
    - Divide: restoring shift-subtract; the quotient bit is 1 when the partial remainder is at least the divisor.
    - After iteration `ITER-1`, go to FIXUP.
  - FIXUP: apply signs, write hi/lo, assert `done`, go to IDLE.
- Sign rules:
  - Signed product is negated if the operand signs differ.
  - Signed quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - Division gives LO = quotient, HI = remainder.
- Division by zero: lo = 32'hFFFFFFFF, hi = opr1 as given (raw, unsigned or signed alike), with the same latency.
- DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- `start` while busy is ignored: no state change, no `illegal_opt`. The issuing stage must not do this.
- `flush` in CALC or FIXUP returns to IDLE the next edge, leaves hi/lo unchanged and gives no `done`. `flush` in IDLE has no effect. `flush` and `start` in the same IDLE cycle: the start is dropped.
- Async reset during CALC abandons the operation immediately; all outputs take their reset values.

## Timing
- `start` sampled at edge E0; `busy` high from E0 through E33 (33 cycles).
- CALC occupies edges E1..E32. FIXUP writes hi/lo at E33. `done` is high for the cycle after E33.
- Latency is 33 cycles for every MULT*/DIV*, including division by zero.
- Back-to-back: a new `start` is accepted in the cycle `done` is high.
- MTHI/MTLO: value is visible on `hi`/`lo` the cycle after the edge; `busy` never rises.
- `done` and `illegal_opt` are registered; no combinational path from inputs to outputs.

## Structure
- Shared header `muldiv_opt.vh`, alongside `alu_opt.vh`: `MD_OPT_WIDTH` (3) and the six opt codes. Decode uses the header macros only.
- Optional sub-module `muldiv_step`: combinational single-iteration step (mul/div select, 64-bit accumulator in and out). The FSM, counter, sign latch and HI/LO registers stay in `muldiv_ctrl`.

## Test plan
- MULTU 0xFFFFFFFF × 2 → after 33 cycles hi=0x00000001, lo=0xFFFFFFFE, one `done` pulse. MULT with the same operands → hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2.
- DIVU 5 / 0 → lo=0xFFFFFFFF, hi=5, latency 33. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Idle MTHI 0x12345678, then MTLO 0xCAFEBABE on consecutive cycles → both visible one cycle after each edge; `busy` stays 0.
- `flush` at CALC iteration 10 after hi/lo preloaded with 0xAAAA_AAAA / 0x5555_5555 → IDLE next edge, no `done`, hi/lo unchanged. Repeat with `rst_n` low mid-CALC instead → hi=lo=0, busy=0 immediately.
- Undefined opt with `start` → `illegal_opt` pulse, busy stays 0. A second `start` issued while busy → ignored, and the first result is correct.
